// File: rtl/instruction_encode_unit.sv
// RV32I field-to-word encoder with a single registered output stage,
// valid/ready handshaking on both sides and saturating delivery statistics.
module instruction_encode_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [2:0]       funct3,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instruction,
  output logic             err,
  input  logic             clr_stats,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [6:0] {
    OPC_R      = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_JALR   = 7'b1100111,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111
  } opcode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic        r_out_valid;
  logic [31:0] r_instruction;
  logic        r_err;
  logic [CNT_W-1:0] r_enc_count;
  logic [CNT_W-1:0] r_err_count;

  logic        w_in_hs;
  logic        w_out_hs;
  logic        w_is_shift;
  logic        w_fits12;
  logic        w_fits13;
  logic        w_fits21;
  logic [31:0] w_word;
  logic        w_err;

  assign in_ready = !r_out_valid || out_ready;
  assign w_in_hs  = in_valid && in_ready;
  assign w_out_hs = r_out_valid && out_ready;

  // Signed range checks: all bits above the field's sign bit must match it.
  assign w_fits12 = (&imm[31:11]) || !(|imm[31:11]);
  assign w_fits13 = (&imm[31:12]) || !(|imm[31:12]);
  assign w_fits21 = (&imm[31:20]) || !(|imm[31:20]);

  assign w_is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case can leave a value unassigned and infer a latch.
    w_word = 32'h0;
    w_err  = 1'b0;
    case (opcode)
      OPC_R: begin
        w_word = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      OPC_OP_IMM: begin
        if (w_is_shift) begin
          w_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
          w_err  = |imm[31:5];
        end else begin
          w_word = {imm[11:0], rs1, funct3, rd, opcode};
          w_err  = !w_fits12;
        end
      end
      OPC_LOAD, OPC_JALR: begin
        w_word = {imm[11:0], rs1, funct3, rd, opcode};
        w_err  = !w_fits12;
      end
      OPC_STORE: begin
        w_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        w_err  = !w_fits12;
      end
      OPC_BRANCH: begin
        w_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        w_err  = !w_fits13 || imm[0];
      end
      OPC_LUI, OPC_AUIPC: begin
        w_word = {imm[31:12], rd, opcode};
        w_err  = |imm[11:0];
      end
      OPC_JAL: begin
        w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        w_err  = !w_fits21 || imm[0];
      end
      default: begin
        w_word = 32'h0;
        w_err  = 1'b1;
      end
    endcase
  end

  // Output stage: load on accept, drop valid when drained without a refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_out_valid   <= 1'b0;
      r_instruction <= 32'h0;
      r_err         <= 1'b0;
    end else if (w_in_hs) begin
      r_out_valid   <= 1'b1;
      r_instruction <= w_word;
      r_err         <= w_err;
    end else if (w_out_hs) begin
      r_out_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_enc_count <= '0;
      r_err_count <= '0;
    end else if (clr_stats) begin
      r_enc_count <= '0;
      r_err_count <= '0;
    end else if (w_out_hs) begin
      if (r_enc_count != CNT_MAX) r_enc_count <= r_enc_count + 1'b1;
      if (r_err && (r_err_count != CNT_MAX)) r_err_count <= r_err_count + 1'b1;
    end
  end

  assign out_valid   = r_out_valid;
  assign instruction = r_instruction;
  assign err         = r_err;
  assign enc_count   = r_enc_count;
  assign err_count   = r_err_count;

endmodule

// File: tb/tb_instruction_encode_unit.sv
// Self-checking bench for instruction_encode_unit: directed vectors, backpressure,
// counter clear/saturation, async reset, and randomized traffic against a field-level model.
module tb_instruction_encode_unit;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [2:0]       funct3;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [6:0]       funct7;
  logic [31:0]      imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      instruction;
  logic             err;
  logic             clr_stats;
  logic [CNT_W-1:0] enc_count;
  logic [CNT_W-1:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: words in flight as {err, word}, plus delivery statistics.
  logic [32:0] m_q[$];
  int unsigned m_enc = 0;
  int unsigned m_errc = 0;

  instruction_encode_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
    .funct7(funct7), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .instruction(instruction), .err(err), .clr_stats(clr_stats),
    .enc_count(enc_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference encoder built from the bit-placement table with integer range checks.
  function automatic logic [32:0] ref_enc(input logic [6:0] op, input logic [4:0] f_rd,
      input logic [2:0] f3, input logic [4:0] f_rs1, input logic [4:0] f_rs2,
      input logic [6:0] f7, input logic [31:0] im);
    logic [31:0] o = op, d = f_rd, a = f3, s1 = f_rs1, s2 = f_rs2, b7 = f7;
    logic [31:0] w;
    logic e;
    int sv = int'($signed(im));
    w = 0; e = 0;
    case (op)
      7'h33: w = (b7 << 25) | (s2 << 20) | (s1 << 15) | (a << 12) | (d << 7) | o;
      7'h13, 7'h03, 7'h67: begin
        if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
          w = (b7 << 25) | ((im % 32) << 20) | (s1 << 15) | (a << 12) | (d << 7) | o;
          e = (im > 31);
        end else begin
          w = ((im & 32'hFFF) << 20) | (s1 << 15) | (a << 12) | (d << 7) | o;
          e = (sv < -2048) || (sv > 2047);
        end
      end
      7'h23: begin
        w = (((im >> 5) & 32'h7F) << 25) | (s2 << 20) | (s1 << 15) | (a << 12)
          | ((im & 32'h1F) << 7) | o;
        e = (sv < -2048) || (sv > 2047);
      end
      7'h63: begin
        w = (((im >> 12) & 1) << 31) | (((im >> 5) & 32'h3F) << 25) | (s2 << 20)
          | (s1 << 15) | (a << 12) | (((im >> 1) & 32'hF) << 8)
          | (((im >> 11) & 1) << 7) | o;
        e = (sv < -4096) || (sv > 4095) || (im % 2 == 1);
      end
      7'h37, 7'h17: begin
        w = (im & 32'hFFFFF000) | (d << 7) | o;
        e = (im % 4096 != 0);
      end
      7'h6F: begin
        w = (((im >> 20) & 1) << 31) | (((im >> 1) & 32'h3FF) << 21)
          | (((im >> 11) & 1) << 20) | (((im >> 12) & 32'hFF) << 12) | (d << 7) | o;
        e = (sv < -1048576) || (sv > 1048575) || (im % 2 == 1);
      end
      default: begin w = 0; e = 1; end
    endcase
    return {e, w};
  endfunction

  task automatic set_bundle(input logic [6:0] op, input logic [4:0] f_rd, input logic [2:0] f3,
      input logic [4:0] f_rs1, input logic [4:0] f_rs2, input logic [6:0] f7, input logic [31:0] im);
    opcode = op; rd = f_rd; funct3 = f3; rs1 = f_rs1; rs2 = f_rs2; funct7 = f7; imm = im;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check({tag, "_instruction"}, instruction, m_q[0][31:0]);
      check({tag, "_err"}, 32'(err), 32'(m_q[0][32]));
    end
    check({tag, "_enc_count"}, 32'(enc_count), m_enc);
    check({tag, "_err_count"}, 32'(err_count), m_errc);
  endtask

  // Called just after a falling edge with inputs already driven; returns after the next one.
  task automatic cycle(input string tag);
    logic exp_ready, in_hs, out_hs;
    logic [32:0] head;
    #1;
    exp_ready = (m_q.size() == 0) || out_ready;
    check({tag, "_in_ready"}, 32'(in_ready), 32'(exp_ready));
    in_hs  = in_valid && exp_ready;
    out_hs = (m_q.size() != 0) && out_ready;
    if (out_hs) begin
      head = m_q.pop_front();
      if (!clr_stats) begin
        if (m_enc < 32'hFFFF) m_enc++;
        if (head[32] && m_errc < 32'hFFFF) m_errc++;
      end
    end
    if (clr_stats) begin m_enc = 0; m_errc = 0; end
    if (in_hs) m_q.push_back(ref_enc(opcode, rd, funct3, rs1, rs2, funct7, imm));
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  function automatic logic [31:0] rand_imm();
    int v;
    case ($urandom_range(0, 4))
      0: v = int'($urandom);
      1: v = int'($urandom_range(0, 10000)) - 5000;
      2: begin
        logic [31:0] edges[8] = '{32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF,
                                  32'd4095, 32'd4094, 32'd31, 32'd32};
        v = int'(edges[$urandom_range(0, 7)]);
      end
      3: v = int'($urandom & 32'hFFFFF000);
      default: v = int'($urandom_range(0, 2097151)) - 1048576;
    endcase
    return 32'(v);
  endfunction

  initial begin
    logic [6:0] ops[10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h00};
    logic [6:0] op_r;
    int unsigned enc_before;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
    set_bundle(7'h0, 5'd0, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_instruction", instruction, 32'h0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_enc_count", 32'(enc_count), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    rst = 1'b0;
    #1 check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors with literal expectations
    out_ready = 1'b1; in_valid = 1'b1;
    set_bundle(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd5);
    cycle("addi");
    check("addi_word", instruction, 32'h00500093);
    check("addi_err", 32'(err), 32'd0);
    set_bundle(7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 7'd0, 32'hFFFFFFFC);
    cycle("beq");
    check("beq_word", instruction, 32'hFE208EE3);
    check("addi_enc_count", 32'(enc_count), 32'd1);
    set_bundle(7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h800);
    cycle("jal");
    check("jal_word", instruction, 32'h001000EF);
    check("jal_err", 32'(err), 32'd0);
    set_bundle(7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd2048);
    cycle("addi_big");
    check("addi_big_word", instruction, 32'h80000093);
    check("addi_big_err", 32'(err), 32'd1);
    set_bundle(7'h7F, 5'd3, 3'd2, 5'd4, 5'd5, 7'd6, 32'd0);
    cycle("bad_op");
    check("bad_op_word", instruction, 32'h0);
    check("bad_op_err", 32'(err), 32'd1);
    check("bad_op_err_count", 32'(err_count), 32'd1);
    set_bundle(7'h37, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'h00001001);
    cycle("lui_bad");
    check("lui_bad_err", 32'(err), 32'd1);
    check("lui_bad_err_count", 32'(err_count), 32'd2);
    in_valid = 1'b0;
    cycle("drain");
    check("drain_err_count", 32'(err_count), 32'd3);
    check("drain_enc_count", 32'(enc_count), 32'd6);

    // Backpressure: hold A, refuse B, then release both in order
    out_ready = 1'b0; in_valid = 1'b1;
    set_bundle(7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd7);
    cycle("bp_a");
    set_bundle(7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'd0, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      cycle("bp_stall");
      check("bp_hold_word", instruction, 32'h00700113);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    check("bp_hold_enc", 32'(enc_count), 32'd6);
    out_ready = 1'b1;
    cycle("bp_release");
    check("bp_b_word", instruction, 32'h002081B3);
    in_valid = 1'b0;
    cycle("bp_drain");
    check("bp_enc_plus2", 32'(enc_count), 32'd8);

    // Clear coincident with a handshake
    in_valid = 1'b1;
    set_bundle(7'h13, 5'd2, 3'd0, 5'd0, 5'd0, 7'd0, 32'd7);
    cycle("clr_fill");
    clr_stats = 1'b1;
    cycle("clr");
    check("clr_enc_zero", 32'(enc_count), 32'd0);
    check("clr_err_zero", 32'(err_count), 32'd0);
    clr_stats = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      op_r = ops[$urandom_range(0, 9)];
      if (op_r == 7'h00) op_r = 7'($urandom);
      set_bundle(op_r, 5'($urandom), 3'($urandom), 5'($urandom), 5'($urandom),
                 7'($urandom), rand_imm());
      in_valid  = 1'($urandom_range(0, 3) != 0);
      out_ready = 1'($urandom_range(0, 3) != 0);
      clr_stats = 1'($urandom_range(0, 49) == 0);
      cycle("rand");
    end
    clr_stats = 1'b0;

    // Asynchronous reset while a word is stalled
    out_ready = 1'b0; in_valid = 1'b1;
    set_bundle(7'h7F, 5'd1, 3'd0, 5'd0, 5'd0, 7'd0, 32'd0);
    cycle("mid_fill");
    check("mid_stalled_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_instruction", instruction, 32'h0);
    check("mid_rst_err", 32'(err), 32'd0);
    check("mid_rst_enc", 32'(enc_count), 32'd0);
    check("mid_rst_errc", 32'(err_count), 32'd0);
    m_q.delete(); m_enc = 0; m_errc = 0;
    rst = 1'b0;
    #1 check("mid_post_in_ready", 32'(in_ready), 32'd1);
    cycle("mid_idle");

    // Saturation of the delivery counter
    out_ready = 1'b1; in_valid = 1'b1;
    set_bundle(7'h33, 5'd1, 3'd0, 5'd2, 5'd3, 7'd0, 32'd0);
    enc_before = m_enc;
    for (int i = 0; i < 65540; i++) cycle("sat");
    check("sat_enc_stuck", 32'(enc_count), 32'hFFFF);
    cycle("sat_more");
    check("sat_enc_hold", 32'(enc_count), 32'hFFFF);
    check("sat_start_zero", enc_before, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
